pcint_ctrl: RTL and testbench
=============================

Name: pcint_ctrl

Overview:
- Pin-change interrupt controller: the consumer side of the GPIO ports.
- Samples the digital pin inputs (DIB_o of Port_B/C/D/E), detects edges on masked pins, and sets per-group flags PCIFn.
- Raises interrupt requests to the interrupt vector unit.
- Exports PCMSKn and PCIEn back to the ports, where they drive the digital-input-enable override (PCINT/PCIE0 inputs of each port).

Parameters:
N_GROUPS, 4, number of pin-change groups (PCIE0..PCIE3).
PCIFR_IO_ADDR, 6'h1B, I/O-space address of PCIFR.
PCICR_ADDR, 8'h68, data-space address of PCICR.
PCMSK_BASE, 8'h6B, data-space address of PCMSK0; PCMSK1 and PCMSK2 follow at +1 and +2.
PCMSK3_ADDR, 8'h73, data-space address of PCMSK3.

Ports:
cp2  input  1  system clock; all state updates on the rising edge.
ireset  input  1  asynchronous active-low reset.
IO_Addr  input  6  I/O-space address.
iore  input  1  I/O read strobe.
iowe  input  1  I/O write strobe.
ramadr  input  8  data-space address (extended I/O).
ramre  input  1  data-space read strobe.
ramwe  input  1  data-space write strobe.
dbus_in  input  8  write data.
dbus_out  output  8  read data; 0 when not selected.
out_en  output  1  high when a read hits any register of this block.
pin_i  input  8*N_GROUPS  pin levels; group n occupies bits [8n+7:8n].
pcmsk_o  output  8*N_GROUPS  current PCMSKn contents, same packing as pin_i.
pcie_o  output  N_GROUPS  current PCICR[N_GROUPS-1:0].
irq  output  N_GROUPS  interrupt request per group, PCIFn AND PCIEn.
irq_ack  input  N_GROUPS  single-cycle acknowledge from the vector unit; clears PCIFn.

Behaviour:
- Reset (ireset=0, asynchronous) clears:
  - PCICR, all PCMSKn, all PCIFn, sync and prev registers, and primed.
  - Outputs: irq=0, pcie_o=0, pcmsk_o=0, dbus_out=0, out_en=0.
- Synchroniser: two flops per pin, sync1 then sync2. A third register, prev, holds sync2 delayed by one cycle.
- Change detect: chg[n] = |((sync2 ^ prev) & PCMSKn) & primed.
- primed: 0 after reset; goes to 1 on the 3rd rising edge after reset release. This suppresses spurious edges while the pipeline fills with real pin values.
- Latency: a pin transition sampled into sync1 at edge k sets PCIFn at edge k+2. irq is visible after edge k+2.
- Edges are detected on every pin regardless of mask. Enabling a mask bit never flags an old change, because prev always tracks sync2.
- Toggle pulses shorter than one cp2 period may be missed; this is accepted behaviour.
- Flag update priority per group, evaluated each edge:
  - set (chg) beats clear.
  - Clear = irq_ack[n], or an I/O write to PCIFR with dbus_in[n]=1.
  - Writing 0 to a PCIFR bit has no effect.
- PCIEn does not gate flag setting; it gates only irq.
- Register writes take effect at the edge where the write strobe is high:
  - PCICR: only bits [N_GROUPS-1:0] are writable; other bits read 0.
  - PCMSKn: all 8 bits writable.
  - PCIFR: write-1-to-clear, as above.
- Reads are combinational:
  - dbus_out = register value before any same-cycle update; out_en=1.
  - PCIFR reads {zeros, flags}.
  - Reads of an unmapped address: dbus_out=0, out_en=0.
- A read and a flag set in the same cycle return the old value; the new value is visible on the next read.
- Groups are fully independent. An event in group n never affects group m.
- Reset mid-operation: all flags drop immediately (asynchronous). The primed window restarts on release.

Decomposition:
- Shared package pcint_pkg holds:
  - Address constants PCIFR_IO_ADDR, PCICR_ADDR, PCMSK_BASE, PCMSK3_ADDR.
  - N_GROUPS default and group width constant PCINT_GRP_W=8.
- Sub-module pcint_group: synchroniser, prev register, masked change detect and the PCIFn flag with set/clear priority. It is instantiated N_GROUPS times.
- The top level holds PCICR, the PCMSKn registers, address decode and read mux.

Test Plan:
- Reset release with pin_i=32'hFFFFFFFF, PCMSK0=8'hFF, PCIE0=1 -> PCIFR stays 8'h00 and irq stays 0 for 10 cycles.
- PCMSK0=8'h04, PCICR=8'h01, toggle pin_i[2] 0->1 -> PCIFR reads 8'h01 and irq[0]=1 exactly 2 edges after sync1 capture. Toggling pin_i[3] instead -> no flag.
- Flag set in group 1, then I/O write PCIFR=8'h02 -> flag and irq[1] clear next edge. Writing 8'hFD instead -> flag remains.
- Write-1-clear of PCIFR bit 0 in the same cycle as a new masked edge in group 0 -> PCIFR bit 0 remains 1.
- PCMSK2=8'h80, PCIE2=0, toggle pin_i[23] -> PCIFR=8'h04, irq[2]=0. Then write PCICR=8'h04 -> irq[2]=1 next edge. Pulse irq_ack[2] -> irq[2]=0.
- Read PCMSK3 at ramadr=8'h73 after writing 8'h5A -> dbus_out=8'h5A, out_en=1. Read ramadr=8'h74 -> dbus_out=0, out_en=0.

Source files
------------

// File: rtl/pcint_ctrl_pkg.sv
// Shared constants for the pin-change interrupt controller: register map,
// group geometry and the post-reset settling window.
package pcint_pkg;

  localparam int N_GROUPS_DEF = 4;
  localparam int PCINT_GRP_W  = 8;
  localparam int PRIME_EDGES  = 3;

  localparam logic [5:0] PCIFR_IO_ADDR = 6'h1B;
  localparam logic [7:0] PCICR_ADDR    = 8'h68;
  localparam logic [7:0] PCMSK_BASE    = 8'h6B;
  localparam logic [7:0] PCMSK3_ADDR   = 8'h73;

  // PCMSK0..2 are contiguous; PCMSK3 (and any later group) sits in a separate window.
  function automatic logic [7:0] pcmsk_addr(input int n);
    if (n < 3) return PCMSK_BASE + 8'(n);
    else       return PCMSK3_ADDR + 8'(n - 3);
  endfunction

endpackage

// File: rtl/pcint_ctrl_if.sv
// CPU register bus shared by the I/O space (PCIFR) and the extended data
// space (PCICR, PCMSKn).
interface pcint_ctrl_if;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;

  modport master (
    output IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in,
    input  dbus_out, out_en
  );

  modport slave (
    input  IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in,
    output dbus_out, out_en
  );
endinterface

// File: rtl/pcint_ctrl_group.sv
// One pin-change group: two-flop synchroniser, delayed copy for edge
// detection, and the PCIFn flag where a new change wins over any clear.
module pcint_group
  import pcint_pkg::*;
(
  input  logic                   cp2,
  input  logic                   ireset,
  input  logic [PCINT_GRP_W-1:0] pin_i,
  input  logic [PCINT_GRP_W-1:0] mask_i,
  input  logic                   primed_i,
  input  logic                   clr_i,
  output logic                   flag_o
);

  logic [PCINT_GRP_W-1:0] sync1_q;
  logic [PCINT_GRP_W-1:0] sync2_q;
  logic [PCINT_GRP_W-1:0] prev_q;
  logic                   flag_q;
  logic                   flag_d;
  logic                   chg;

  // prev follows sync2 unconditionally so a newly enabled mask bit never sees a stale edge
  assign chg = (|((sync2_q ^ prev_q) & mask_i)) & primed_i;

  always_comb begin
    flag_d = flag_q;
    if (chg)        flag_d = 1'b1;
    else if (clr_i) flag_d = 1'b0;
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      flag_q  <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller top: PCICR/PCMSKn registers, address
// decode, read mux and one pcint_group per port.
module pcint_ctrl
  import pcint_pkg::*;
#(
  parameter int N_GROUPS = N_GROUPS_DEF
) (
  input  logic                          cp2,
  input  logic                          ireset,
  pcint_ctrl_if.slave                   bus,
  input  logic [PCINT_GRP_W*N_GROUPS-1:0] pin_i,
  output logic [PCINT_GRP_W*N_GROUPS-1:0] pcmsk_o,
  output logic [N_GROUPS-1:0]           pcie_o,
  output logic [N_GROUPS-1:0]           irq,
  input  logic [N_GROUPS-1:0]           irq_ack
);

  logic [1:0]             prime_cnt_q;
  logic [1:0]             prime_cnt_d;
  logic                   primed;
  logic [N_GROUPS-1:0]    pcicr_q;
  logic [N_GROUPS-1:0]    pcicr_d;
  logic [PCINT_GRP_W-1:0] pcmsk_q [N_GROUPS];
  logic [PCINT_GRP_W-1:0] pcmsk_d [N_GROUPS];
  logic [N_GROUPS-1:0]    flag;
  logic [N_GROUPS-1:0]    clr;
  logic                   pcifr_wr;
  logic [7:0]             rd_data;
  logic                   rd_hit;

  // Settling window: down-counter, primed at terminal count
  assign primed = (prime_cnt_q == 2'd0);

  always_comb begin
    prime_cnt_d = prime_cnt_q;
    if (!primed) prime_cnt_d = prime_cnt_q - 2'd1;
  end

  assign pcifr_wr = bus.iowe && (bus.IO_Addr == PCIFR_IO_ADDR);

  always_comb begin
    pcicr_d = pcicr_q;
    if (bus.ramwe && (bus.ramadr == PCICR_ADDR)) pcicr_d = bus.dbus_in[N_GROUPS-1:0];
    for (int n = 0; n < N_GROUPS; n++) begin
      pcmsk_d[n] = pcmsk_q[n];
      if (bus.ramwe && (bus.ramadr == pcmsk_addr(n))) pcmsk_d[n] = bus.dbus_in;
      clr[n] = irq_ack[n] | (pcifr_wr & bus.dbus_in[n]);
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      prime_cnt_q <= 2'(PRIME_EDGES);
      pcicr_q     <= '0;
      for (int n = 0; n < N_GROUPS; n++) pcmsk_q[n] <= '0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      pcicr_q     <= pcicr_d;
      for (int n = 0; n < N_GROUPS; n++) pcmsk_q[n] <= pcmsk_d[n];
    end
  end

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
    pcint_group u_grp (
      .cp2      (cp2),
      .ireset   (ireset),
      .pin_i    (pin_i[g*PCINT_GRP_W +: PCINT_GRP_W]),
      .mask_i   (pcmsk_q[g]),
      .primed_i (primed),
      .clr_i    (clr[g]),
      .flag_o   (flag[g])
    );
    assign pcmsk_o[g*PCINT_GRP_W +: PCINT_GRP_W] = pcmsk_q[g];
  end

  // Reads return pre-edge register contents
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (bus.iore && (bus.IO_Addr == PCIFR_IO_ADDR)) begin
      rd_hit              = 1'b1;
      rd_data[N_GROUPS-1:0] = flag;
    end
    if (bus.ramre) begin
      if (bus.ramadr == PCICR_ADDR) begin
        rd_hit              = 1'b1;
        rd_data[N_GROUPS-1:0] = pcicr_q;
      end
      for (int n = 0; n < N_GROUPS; n++) begin
        if (bus.ramadr == pcmsk_addr(n)) begin
          rd_hit  = 1'b1;
          rd_data = pcmsk_q[n];
        end
      end
    end
  end

  assign bus.dbus_out = rd_data;
  assign bus.out_en   = rd_hit;
  assign pcie_o       = pcicr_q;
  assign irq          = flag & pcicr_q;

endmodule

// File: tb/tb_pcint_ctrl.sv
// Bench for pcint_ctrl: register-map vector table, directed corner-case
// sequences and a randomized run against a sample-history reference model.
module tb_pcint_ctrl;
  import pcint_pkg::*;

  localparam int NG = 4;

  logic          cp2 = 1'b0;
  logic          ireset = 1'b0;
  logic [31:0]   pin_i = '0;
  logic [31:0]   pcmsk_o;
  logic [NG-1:0] pcie_o;
  logic [NG-1:0] irq;
  logic [NG-1:0] irq_ack = '0;

  int checks = 0;
  int errors = 0;

  pcint_ctrl_if bus ();

  pcint_ctrl #(.N_GROUPS(NG)) dut (
    .cp2     (cp2),
    .ireset  (ireset),
    .bus     (bus),
    .pin_i   (pin_i),
    .pcmsk_o (pcmsk_o),
    .pcie_o  (pcie_o),
    .irq     (irq),
    .irq_ack (irq_ack)
  );

  always #5 cp2 = ~cp2;

  // Reference model: a group flags when the pin samples taken two and three
  // edges ago differ on a masked bit, and only once four post-reset samples exist.
  logic [7:0]    m_mask [NG];
  logic [NG-1:0] m_ie;
  logic [NG-1:0] m_flag;
  logic [NG-1:0] m_set;
  logic [NG-1:0] m_clr;
  logic [31:0]   m_hist [$];

  always @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      for (int g = 0; g < NG; g++) m_mask[g] = '0;
      m_ie   = '0;
      m_flag = '0;
      m_hist.delete();
    end else begin
      m_hist.push_back(pin_i);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      for (int g = 0; g < NG; g++) begin
        m_set[g] = (m_hist.size() == 4) &&
                   ((((m_hist[1] ^ m_hist[0]) >> (8 * g)) & {24'h0, m_mask[g]}) != 32'h0);
        m_clr[g] = irq_ack[g] || (bus.iowe && bus.IO_Addr == 6'h1B && bus.dbus_in[g]);
        if (m_set[g])      m_flag[g] = 1'b1;
        else if (m_clr[g]) m_flag[g] = 1'b0;
      end
      if (bus.ramwe) begin
        case (bus.ramadr)
          8'h68: m_ie = bus.dbus_in[NG-1:0];
          8'h6B: m_mask[0] = bus.dbus_in;
          8'h6C: m_mask[1] = bus.dbus_in;
          8'h6D: m_mask[2] = bus.dbus_in;
          8'h73: m_mask[3] = bus.dbus_in;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  task automatic bus_idle();
    bus.IO_Addr = '0; bus.iore = 1'b0; bus.iowe = 1'b0;
    bus.ramadr  = '0; bus.ramre = 1'b0; bus.ramwe = 1'b0;
    bus.dbus_in = '0;
  endtask

  task automatic do_reset();
    ireset = 1'b0;
    bus_idle();
    irq_ack = '0;
    repeat (2) @(negedge cp2);
    ireset = 1'b1;
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    bus.IO_Addr = a; bus.dbus_in = d; bus.iowe = 1'b1;
    tick();
    bus.iowe = 1'b0;
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
    bus.ramadr = a; bus.dbus_in = d; bus.ramwe = 1'b1;
    tick();
    bus.ramwe = 1'b0;
  endtask

  task automatic io_rd(input logic [5:0] a, output logic [7:0] d, output logic en);
    bus.IO_Addr = a; bus.iore = 1'b1;
    #1;
    d = bus.dbus_out; en = bus.out_en;
    bus.iore = 1'b0;
  endtask

  task automatic ram_rd(input logic [7:0] a, output logic [7:0] d, output logic en);
    bus.ramadr = a; bus.ramre = 1'b1;
    #1;
    d = bus.dbus_out; en = bus.out_en;
    bus.ramre = 1'b0;
  endtask

  task automatic chk_pcifr(input string name, input logic [7:0] expv);
    logic [7:0] d;
    logic       en;
    io_rd(PCIFR_IO_ADDR, d, en);
    chk(name, {23'h0, en, d}, {23'h0, 1'b1, expv});
  endtask

  typedef struct {
    bit         io;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_en;
  } reg_vec_t;

  reg_vec_t vecs [12];

  initial begin
    logic [7:0] d;
    logic       en;
    int         op;
    logic [7:0] maddr [4];

    bus_idle();

    // Register map table
    vecs[0]  = '{0, 1, 8'h68, 8'hFF, 8'h0F, 1};
    vecs[1]  = '{0, 1, 8'h6B, 8'hA5, 8'hA5, 1};
    vecs[2]  = '{0, 1, 8'h6C, 8'h3C, 8'h3C, 1};
    vecs[3]  = '{0, 1, 8'h6D, 8'hC3, 8'hC3, 1};
    vecs[4]  = '{0, 1, 8'h73, 8'h5A, 8'h5A, 1};
    vecs[5]  = '{0, 0, 8'h74, 8'h00, 8'h00, 0};
    vecs[6]  = '{0, 0, 8'h6E, 8'h00, 8'h00, 0};
    vecs[7]  = '{0, 0, 8'h6A, 8'h00, 8'h00, 0};
    vecs[8]  = '{0, 0, 8'h1B, 8'h00, 8'h00, 0};
    vecs[9]  = '{1, 0, 8'h1B, 8'h00, 8'h00, 1};
    vecs[10] = '{1, 0, 8'h28, 8'h00, 8'h00, 0};
    vecs[11] = '{0, 0, 8'h68, 8'h00, 8'h0F, 1};

    #2;
    chk("reset_irq", {28'h0, irq}, 32'h0);
    chk("reset_pcmsk", pcmsk_o, 32'h0);
    chk("reset_pcie", {28'h0, pcie_o}, 32'h0);
    chk("reset_dbus", {23'h0, bus.out_en, bus.dbus_out}, 32'h0);

    do_reset();
    repeat (4) tick();
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) ram_wr(vecs[i].addr, vecs[i].wdata);
      if (vecs[i].io) io_rd(vecs[i].addr[5:0], d, en);
      else            ram_rd(vecs[i].addr, d, en);
      chk($sformatf("vec%0d_rd", i), {23'h0, en, d}, {23'h0, vecs[i].exp_en, vecs[i].exp_rd});
    end
    chk("vec_pcmsk_o", pcmsk_o, 32'h5AC33CA5);
    chk("vec_pcie_o", {28'h0, pcie_o}, 32'h0000000F);

    // Pipeline fill after reset must not flag
    pin_i = 32'hFFFFFFFF;
    do_reset();
    ram_wr(8'h6B, 8'hFF);
    ram_wr(8'h68, 8'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_pcifr("prime_pcifr", 8'h00);
      chk("prime_irq", {28'h0, irq}, 32'h0);
    end

    // Latency: sampled at edge k, flagged at edge k+2
    pin_i = '0;
    do_reset();
    repeat (5) tick();
    ram_wr(8'h6B, 8'h04);
    ram_wr(8'h68, 8'h01);
    pin_i[2] = 1'b1;
    tick();
    chk("lat_k", {28'h0, irq}, 32'h0);
    tick();
    chk("lat_k1", {28'h0, irq}, 32'h0);
    tick();
    chk("lat_k2_irq", {28'h0, irq}, 32'h1);
    chk_pcifr("lat_k2_pcifr", 8'h01);
    io_wr(PCIFR_IO_ADDR, 8'h01);
    chk("w1c_g0", {28'h0, irq}, 32'h0);
    pin_i[3] = 1'b1;
    repeat (4) tick();
    chk_pcifr("unmasked_pin", 8'h00);

    // Group 1 flag: writing 0 bits leaves it, writing 1 clears it
    ram_wr(8'h6C, 8'h01);
    ram_wr(8'h68, 8'h03);
    pin_i[8] = 1'b1;
    repeat (3) tick();
    io_wr(PCIFR_IO_ADDR, 8'hFD);
    chk_pcifr("w0_keeps", 8'h02);
    chk("w0_keeps_irq", {28'h0, irq}, 32'h2);
    io_wr(PCIFR_IO_ADDR, 8'h02);
    chk_pcifr("w1_clears", 8'h00);
    chk("w1_clears_irq", {28'h0, irq}, 32'h0);

    // Set beats same-edge write-1-clear
    pin_i[2] = 1'b0;
    repeat (3) tick();
    chk_pcifr("g0_set", 8'h01);
    pin_i[2] = 1'b1;
    tick();
    tick();
    io_wr(PCIFR_IO_ADDR, 8'h01);
    chk_pcifr("set_beats_clr", 8'h01);
    io_wr(PCIFR_IO_ADDR, 8'hFF);
    chk_pcifr("clr_all", 8'h00);

    // PCIE gates irq only; ack clears
    ram_wr(8'h6D, 8'h80);
    pin_i[23] = 1'b1;
    repeat (3) tick();
    chk_pcifr("g2_flag_noie", 8'h04);
    chk("g2_irq_noie", {28'h0, irq}, 32'h0);
    ram_wr(8'h68, 8'h07);
    chk("g2_irq_ie", {28'h0, irq}, 32'h4);
    irq_ack = 4'b0100;
    tick();
    irq_ack = '0;
    chk("g2_ack_irq", {28'h0, irq}, 32'h0);
    chk_pcifr("g2_ack_pcifr", 8'h00);

    // Asynchronous reset mid-operation
    pin_i[2] = 1'b0;
    repeat (3) tick();
    chk("pre_rst_irq", {28'h0, irq}, 32'h1);
    #2;
    ireset = 1'b0;
    #1;
    chk("async_rst_irq", {28'h0, irq}, 32'h0);
    chk("async_rst_pcie", {28'h0, pcie_o}, 32'h0);
    chk("async_rst_pcmsk", pcmsk_o, 32'h0);

    // Randomized run against the model
    maddr[0] = 8'h6B; maddr[1] = 8'h6C; maddr[2] = 8'h6D; maddr[3] = 8'h73;
    pin_i = $urandom;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 2) == 0) pin_i[$urandom_range(0, 31)] ^= 1'b1;
      irq_ack = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      op = $urandom_range(0, 6);
      case (op)
        2: begin bus.IO_Addr = PCIFR_IO_ADDR; bus.dbus_in = 8'($urandom); bus.iowe = 1'b1; end
        3: begin bus.ramadr = 8'h68; bus.dbus_in = 8'($urandom); bus.ramwe = 1'b1; end
        4, 5: begin bus.ramadr = maddr[$urandom_range(0, 3)]; bus.dbus_in = 8'($urandom); bus.ramwe = 1'b1; end
        6: begin
          io_rd(PCIFR_IO_ADDR, d, en);
          chk("rnd_pcifr", {23'h0, en, d}, {23'h0, 1'b1, 4'h0, m_flag});
        end
        default: ;
      endcase
      tick();
      bus_idle();
      irq_ack = '0;
      chk("rnd_irq", {28'h0, irq}, {28'h0, m_flag & m_ie});
      if (cyc % 8 == 0) begin
        chk("rnd_pcmsk", pcmsk_o, {m_mask[3], m_mask[2], m_mask[1], m_mask[0]});
        chk("rnd_pcie", {28'h0, pcie_o}, {28'h0, m_ie});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
